estendedor_pulso: RTL and testbench

- Converts a single-cycle request pulse into a timed output level: the pulse-to-level counterpart of the stopwatch rising-edge detector.
- Drives level-type consumers such as buzzer enable, LED flash or display blank from pulses produced by edge detection or control logic.
- Output duration and post-pulse hold-off are counted in timebase ticks, for example a 1 kHz enable from the divider.
- Includes busy, end-of-pulse and overrun status.

---
 rtl/cronometro_pkg.sv | 24 ++
 rtl/contador_descendente.sv | 26 ++
 rtl/estendedor_pulso.sv | 155 +++++++++++++++
 tb/tb_estendedor_pulso.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch pulse helpers: FSM state encoding and counter sizing.
package cronometro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

    localparam int TICK_CNT_W = 8;

    // True when a cnt_w-bit counter can hold the larger of the two loaded lengths.
    function automatic bit cnt_fits(input int cnt_w, input int pulse_len, input int gap_len);
        longint biggest;
        longint cap;
        biggest = (pulse_len > gap_len) ? longint'(pulse_len) : longint'(gap_len);
        if (cnt_w >= 62) begin
            return 1'b1;
        end
        cap = longint'(1) << cnt_w;
        return cap > biggest;
    endfunction

endpackage

// File: rtl/contador_descendente.sv
// Loadable down-counter; load has priority over decrement, is_one flags the final count.
module contador_descendente #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic [CNT_W-1:0] count,
    output logic             is_one
);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec_en) begin
            count <= count - CNT_W'(1);
        end
    end

    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/estendedor_pulso.sv
// Stretches a one-cycle request into a level lasting PULSE_LEN ticks, then a GAP_LEN-tick hold-off.
// Define ESTENDEDOR_RETRIGGER_EN to let requests during the pulse restart it instead of flagging overrun.
module estendedor_pulso
    import cronometro_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2,
    parameter int CNT_W     = TICK_CNT_W
) (
    input  logic clock,
    input  logic clear,
    input  logic pulse_in,
    input  logic tick_en,
    output logic level_out,
    output logic busy,
    output logic done,
    output logic overrun
);

    if (!cnt_fits(CNT_W, PULSE_LEN, GAP_LEN)) begin : g_bad_cnt_w
        $error("estendedor_pulso: CNT_W too narrow for PULSE_LEN/GAP_LEN");
    end
    if (PULSE_LEN < 1 || GAP_LEN < 0) begin : g_bad_len
        $error("estendedor_pulso: PULSE_LEN must be >= 1 and GAP_LEN >= 0");
    end

    localparam logic [CNT_W-1:0] PULSE_V = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(GAP_LEN);
    localparam bit               HAS_GAP = (GAP_LEN > 0);

    state_t           state;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             dec_en;
    logic [CNT_W-1:0] count;
    logic             is_one;
    logic             last_tick;

    contador_descendente #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .dec_en   (dec_en),
        .count    (count),
        .is_one   (is_one)
    );

    // A zero count while counting can only come from corruption; ending the phase keeps the FSM from wrapping.
    assign last_tick = tick_en && (is_one || (count == '0));

    // Counter control: loading GAP_V at pulse end leaves the counter at 0 when there is no hold-off.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        dec_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pulse_in) begin
                    load     = 1'b1;
                    load_val = PULSE_V;
                end
            end
            ST_ACTIVE: begin
`ifdef ESTENDEDOR_RETRIGGER_EN
                if (pulse_in) begin
                    load     = 1'b1;
                    load_val = PULSE_V;
                end else if (last_tick) begin
                    load     = 1'b1;
                    load_val = GAP_V;
                end else begin
                    dec_en = tick_en;
                end
`else
                if (last_tick) begin
                    load     = 1'b1;
                    load_val = GAP_V;
                end else begin
                    dec_en = tick_en;
                end
`endif
            end
            ST_HOLDOFF: begin
                if (last_tick) begin
                    load     = 1'b1;
                    load_val = '0;
                end else begin
                    dec_en = tick_en;
                end
            end
            default: begin
                load     = 1'b1;
                load_val = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= ST_IDLE;
            level_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pulse_in) begin
                        state     <= ST_ACTIVE;
                        level_out <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
`ifdef ESTENDEDOR_RETRIGGER_EN
                    if (!pulse_in && last_tick) begin
`else
                    if (pulse_in) begin
                        overrun <= 1'b1;
                    end
                    if (last_tick) begin
`endif
                        level_out <= 1'b0;
                        done      <= 1'b1;
                        if (HAS_GAP) begin
                            state <= ST_HOLDOFF;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (pulse_in) begin
                        overrun <= 1'b1;
                    end
                    if (last_tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    level_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_estendedor_pulso.sv
// Scoreboard bench for estendedor_pulso: three parameter sets driven by shared random stimulus.
module tb_estendedor_pulso;

    localparam int N = 3;

`ifdef ESTENDEDOR_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic         clock;
    logic         clear;
    logic         pulse_in;
    logic         tick_en;
    logic [N-1:0] level_out;
    logic [N-1:0] busy;
    logic [N-1:0] done;
    logic [N-1:0] overrun;

    int hi_left  [N];
    int gap_left [N];
    bit m_ovr    [N];

    logic [4*N-1:0] exp_q[$];

    int n_vectors;
    int n_miscompares;
    int cyc;

    estendedor_pulso #(.PULSE_LEN(4), .GAP_LEN(2), .CNT_W(8)) dut0 (
        .clock(clock), .clear(clear), .pulse_in(pulse_in), .tick_en(tick_en),
        .level_out(level_out[0]), .busy(busy[0]), .done(done[0]), .overrun(overrun[0]));
    estendedor_pulso #(.PULSE_LEN(2), .GAP_LEN(0), .CNT_W(4)) dut1 (
        .clock(clock), .clear(clear), .pulse_in(pulse_in), .tick_en(tick_en),
        .level_out(level_out[1]), .busy(busy[1]), .done(done[1]), .overrun(overrun[1]));
    estendedor_pulso #(.PULSE_LEN(1), .GAP_LEN(1), .CNT_W(2)) dut2 (
        .clock(clock), .clear(clear), .pulse_in(pulse_in), .tick_en(tick_en),
        .level_out(level_out[2]), .busy(busy[2]), .done(done[2]), .overrun(overrun[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int plen(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int glen(input int i);
        case (i)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    // Reference: ticks of level remaining, then ticks of hold-off remaining; expected value is post-edge output.
    task automatic model_step(input int i, input bit p, input bit t, output logic [3:0] e);
        bit dn;
        dn = 1'b0;
        if (hi_left[i] > 0) begin
            if (p && RETRIG) begin
                hi_left[i] = plen(i);
            end else begin
                if (p) m_ovr[i] = 1'b1;
                if (t) begin
                    hi_left[i] = hi_left[i] - 1;
                    if (hi_left[i] == 0) begin
                        dn          = 1'b1;
                        gap_left[i] = glen(i);
                    end
                end
            end
        end else if (gap_left[i] > 0) begin
            if (p) m_ovr[i] = 1'b1;
            if (t) gap_left[i] = gap_left[i] - 1;
        end else if (p) begin
            hi_left[i] = plen(i);
        end
        e = {hi_left[i] > 0, (hi_left[i] > 0) || (gap_left[i] > 0), dn, m_ovr[i]};
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hi_left[i]  = 0;
            gap_left[i] = 0;
            m_ovr[i]    = 1'b0;
        end
    endtask

    task automatic check_output(input string name, input int i, input logic [3:0] want);
        logic [3:0] got;
        got = {level_out[i], busy[i], done[i], overrun[i]};
        n_vectors++;
        if (got !== want) begin
            n_miscompares++;
            $display("[TB] FAIL %s inst%0d t=%0t {level,busy,done,overrun} got=%b expected=%b",
                     name, i, $time, got, want);
        end
    endtask

    task automatic apply_stimulus(input bit p, input bit t);
        logic [4*N-1:0] ev;
        logic [3:0]     e;
        @(negedge clock);
        clear    = 1'b0;
        pulse_in = p;
        tick_en  = t;
        for (int i = 0; i < N; i++) begin
            model_step(i, p, t, e);
            ev[i*4 +: 4] = e;
        end
        exp_q.push_back(ev);
        cyc++;
    endtask

    // Clear lands between edges; outputs must already be zero before the next edge.
    task automatic apply_clear();
        @(negedge clock);
        pulse_in = 1'b0;
        tick_en  = 1'b1;
        #2 clear = 1'b1;
        #1;
        for (int i = 0; i < N; i++) check_output("async_clear", i, 4'b0000);
        model_reset();
        exp_q.push_back('0);
        cyc++;
    endtask

    initial begin : monitor
        logic [4*N-1:0] ev;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                for (int i = 0; i < N; i++) check_output("scoreboard", i, ev[i*4 +: 4]);
            end
        end
    end

    initial begin : driver
        int hold;
        bit p;
        bit t;
        n_vectors     = 0;
        n_miscompares = 0;
        cyc           = 0;
        hold          = 0;
        clear         = 1'b1;
        pulse_in      = 1'b0;
        tick_en       = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < N; i++) check_output("reset_state", i, 4'b0000);

        for (int k = 0; k < 9; k++) apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        apply_clear();
        for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       t = 1'b1;
                1:       t = (c % 4 == 0);
                default: t = ($urandom_range(0, 1) == 1);
            endcase
            if (hold > 0) begin
                p    = 1'b1;
                hold = hold - 1;
            end else begin
                p = ($urandom_range(0, 5) == 0);
                if (p && $urandom_range(0, 7) == 0) hold = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 249) == 0) apply_clear();
            else apply_stimulus(p, t);
        end

        repeat (3) @(posedge clock);
        #2;
        n_vectors++;
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
